modular_adder: RTL and testbench

MODULAR_ADDER -- requirements
Module: modular_adder

---
 rtl/ddp_pkg.sv | 19 +
 rtl/modular_adder_mpadder.sv | 59 +++++
 rtl/modular_adder.sv | 127 ++++++++++++
 tb/tb_modular_adder.sv | 132 +++++++++++++
 4 files changed

// File: rtl/ddp_pkg.sv
// ddp_pkg: shared project constants and types for the datapath blocks.
//   DDP_WIDTH      operand/modulus width shared by mpadder and modular_adder
//   MPADDER_LADD   cycles from mpadder start to its done pulse (>= 1)
//   ma_state_e     modular_adder FSM state encoding
package ddp_pkg;

  localparam int unsigned DDP_WIDTH    = 514;
  localparam int unsigned MPADDER_LADD = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE1,
    ST_WAIT1,
    ST_ISSUE2,
    ST_WAIT2,
    ST_DONE
  } ma_state_e;

endpackage

// File: rtl/modular_adder_mpadder.sv
// mpadder: multi-precision adder/subtractor with a fixed LADD-cycle latency.
//   clk, resetn      clock, synchronous active-low reset
//   start            one-cycle request; operands sampled with it
//   subtract         0 = a + b, 1 = a - b (two's complement, carry = no borrow)
//   in_a, in_b       WIDTH-bit operands
//   result           WIDTH+1-bit sum; bit WIDTH is the carry out
//   done             one-cycle pulse LADD cycles after start
module mpadder
  import ddp_pkg::*;
#(
  parameter int unsigned WIDTH = DDP_WIDTH,
  parameter int unsigned LADD  = MPADDER_LADD
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             done
);

  localparam logic [7:0] LADD_C = 8'(LADD);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] result_q;
  logic [7:0]     cnt_q;
  logic           done_q;

  // a - b as a + ~b + 1 so the carry out is set exactly when a >= b.
  always_comb begin
    sum = '0;
    if (subtract) sum = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
    else          sum = {1'b0, in_a} + {1'b0, in_b};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      result_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else if (start) begin
      result_q <= sum;
      cnt_q    <= LADD_C;
      done_q   <= (LADD == 1);
    end else if (cnt_q > 8'd1) begin
      cnt_q  <= cnt_q - 8'd1;
      done_q <= (cnt_q == 8'd2);
    end else begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: rtl/modular_adder.sv
// modular_adder: constant-time (a + b) mod M or (a - b) mod M using one
// time-shared mpadder over two passes; selection uses adder carry bits only.
//   clk, resetn      clock, synchronous active-low reset
//   start            one-cycle request, sampled only in IDLE
//   subtract         0 = add, 1 = subtract; captured with start
//   in_a, in_b       operands, each < M
//   in_m             modulus, 0 < M < 2^(WIDTH-1)
//   result           modular result, held until the next operation completes
//   done             one-cycle pulse when result is valid
//   busy             high from the cycle after start through the done cycle
module modular_adder
  import ddp_pkg::*;
#(
  parameter int unsigned WIDTH = DDP_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  ma_state_e        state_q;
  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic             sub_q;
  logic [WIDTH:0]   s_q;
  logic [WIDTH-1:0] result_q;
  logic             done_q, busy_q, mp_start_q;

  logic             pass2;
  logic [WIDTH-1:0] mp_a, mp_b;
  logic             mp_sub;
  logic [WIDTH:0]   mp_res;
  logic             mp_done;

  // Pass 1 works on the captured operands; pass 2 corrects s by M in the
  // opposite direction. The mpadder samples these in the first WAITx cycle.
  always_comb begin
    pass2  = (state_q == ST_ISSUE2) || (state_q == ST_WAIT2);
    mp_a   = pass2 ? s_q[WIDTH-1:0] : a_q;
    mp_b   = pass2 ? m_q : b_q;
    mp_sub = pass2 ? ~sub_q : sub_q;
  end

  mpadder #(
    .WIDTH (WIDTH),
    .LADD  (MPADDER_LADD)
  ) u_mpadder (
    .clk      (clk),
    .resetn   (resetn),
    .start    (mp_start_q),
    .subtract (mp_sub),
    .in_a     (mp_a),
    .in_b     (mp_b),
    .result   (mp_res),
    .done     (mp_done)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= '0;
      sub_q      <= 1'b0;
      s_q        <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mp_start_q <= 1'b0;
    end else begin
      mp_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= in_a;
            b_q     <= in_b;
            m_q     <= in_m;
            sub_q   <= subtract;
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE1;
          end
        end
        ST_ISSUE1: begin
          mp_start_q <= 1'b1;
          state_q    <= ST_WAIT1;
        end
        ST_WAIT1: begin
          if (mp_done) begin
            s_q     <= mp_res;
            state_q <= ST_ISSUE2;
          end
        end
        ST_ISSUE2: begin
          mp_start_q <= 1'b1;
          state_q    <= ST_WAIT2;
        end
        ST_WAIT2: begin
          if (mp_done) begin
            // add: keep s - M when it did not borrow (s >= M)
            // sub: keep a - b when it did not borrow, else the +M correction
            if (sub_q) result_q <= s_q[WIDTH]    ? s_q[WIDTH-1:0]    : mp_res[WIDTH-1:0];
            else       result_q <= mp_res[WIDTH] ? mp_res[WIDTH-1:0] : s_q[WIDTH-1:0];
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_modular_adder.sv
// tb_modular_adder: directed vectors with hand-computed expected results,
// latency, busy/done framing, start-while-busy and mid-operation reset.
module tb_modular_adder;
  import ddp_pkg::*;

  localparam int unsigned W   = 514;
  localparam int          LAT = 2 * int'(MPADDER_LADD) + 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic         subtract;
  logic [W-1:0] in_a, in_b, in_m;
  logic [W-1:0] result;
  logic         done, busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] m13, m_big, one_w;

  modular_adder #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .subtract (subtract),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_m     (in_m),
    .result   (result),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // idle cycle following done so calls can be issued back to back.
  // mode 1 pulses start with other operands while the op is in WAIT1.
  task automatic run_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic sub, input logic [W-1:0] exp,
                        input int mode);
    int cycles;
    int busy_drops;
    in_m = m; in_a = a; in_b = b; subtract = sub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_a = ~a; in_b = ~b; in_m = ~m; subtract = ~sub;
    cycles = 0;
    busy_drops = 0;
    check({tag, "_busy_start"}, W'(busy), W'(1));
    while (done !== 1'b1 && cycles < 40) begin
      if (mode == 1 && cycles == 1) begin
        start = 1'b1; in_a = W'(2); in_b = W'(2); in_m = W'(5); subtract = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
      if (busy !== 1'b1) busy_drops++;
    end
    start = 1'b0;
    check({tag, "_latency"}, W'(cycles), W'(LAT));
    check({tag, "_result"}, result, exp);
    check({tag, "_busy_hold"}, W'(busy_drops), W'(0));
    @(negedge clk);
    check({tag, "_done_pulse"}, W'(done), W'(0));
    check({tag, "_busy_end"}, W'(busy), W'(0));
    check({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m13 = W'(13);
    one_w = W'(1);
    m_big = '0;
    m_big[W-2:0] = '1;

    resetn = 1'b0; start = 1'b0; subtract = 1'b0;
    in_a = '0; in_b = '0; in_m = '0;
    repeat (3) @(negedge clk);
    check("rst_done", W'(done), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_result", result, '0);
    resetn = 1'b1;
    @(negedge clk);

    run_op("add_7_9",   m13, W'(7),  W'(9),  1'b0, W'(3),  0);
    run_op("add_6_7",   m13, W'(6),  W'(7),  1'b0, W'(0),  0);
    run_op("add_5_6",   m13, W'(5),  W'(6),  1'b0, W'(11), 0);
    run_op("sub_9_9",   m13, W'(9),  W'(9),  1'b1, W'(0),  0);
    run_op("sub_3_10",  m13, W'(3),  W'(10), 1'b1, W'(6),  0);
    run_op("sub_10_3",  m13, W'(10), W'(3),  1'b1, W'(7),  0);
    run_op("big_add",   m_big, m_big - one_w, m_big - one_w, 1'b0, m_big - W'(2), 0);
    run_op("big_sub",   m_big, '0, m_big - one_w, 1'b1, one_w, 0);
    run_op("busy_start", m13, W'(7), W'(9), 1'b0, W'(3), 1);

    // Reset while the second pass is in flight (WAIT2 spans edges 5..8).
    in_m = m13; in_a = W'(12); in_b = W'(12); subtract = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_busy_before", W'(busy), W'(1));
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_done", W'(done), W'(0));
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_result", result, '0);
    resetn = 1'b1;
    @(negedge clk);
    run_op("post_rst", m13, W'(7), W'(9), 1'b0, W'(3), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
